// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: conditions the four raw menu keys, owns the level cursor/selection and sequences MENU/LOAD/PLAY/PAUSE/WIN/LOSE.
// Optional feature: define PAUSE_EN to enable the pause key and the PAUSE state (default build has no pause).
module game_flow_ctrl #(
    parameter int NUM_LEVELS      = 5,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int END_SCREEN_SECS = 3
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       oneSec,
    input  logic       up_keyN,
    input  logic       down_keyN,
    input  logic       slct_keyN,
    input  logic       pause_keyN,
    input  logic       lvl_won,
    input  logic       player_dead,
    output logic       menu_screen_on,
    output logic       game_run,
    output logic       game_load,
    output logic       win_screen_on,
    output logic       lose_screen_on,
    output logic [2:0] cursor,
    output logic [2:0] selected_lvl,
    output logic [2:0] state_dbg
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SEC_W = $clog2(END_SCREEN_SECS + 1);
    localparam logic [2:0]       LAST_LVL = 3'(NUM_LEVELS - 1);
    localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(END_SCREEN_SECS - 1);

    localparam int K_UP    = 0;
    localparam int K_DOWN  = 1;
    localparam int K_SLCT  = 2;
    localparam int K_PAUSE = 3;

    typedef enum logic [2:0] {
        S_MENU  = 3'd0,
        S_LOAD  = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_WIN   = 3'd4,
        S_LOSE  = 3'd5
    } state_t;

    // ---------------- key conditioning ----------------
    // All key vectors are active-low levels; '1' means released.
    logic [3:0]      key_raw;
    logic [3:0]      sync_1;
    logic [3:0]      sync_2;
    logic [3:0]      sync_d;
    logic [3:0]      stable;
    logic [3:0]      stable_d;
    logic [3:0]      key_evt;
    logic [DB_W-1:0] db_cnt [4];

    assign key_raw = {pause_keyN, slct_keyN, down_keyN, up_keyN};

    always_ff @(posedge clk) begin
        if (!resetN) begin
            sync_1   <= '1;
            sync_2   <= '1;
            sync_d   <= '1;
            stable   <= '1;
            stable_d <= '1;
            for (int k = 0; k < 4; k++) begin
                db_cnt[k] <= '0;
            end
        end else begin
            sync_1   <= key_raw;
            sync_2   <= sync_1;
            sync_d   <= sync_2;
            stable_d <= stable;
            // Count only while the synced level is steady and differs from the accepted level.
            for (int k = 0; k < 4; k++) begin
                if ((sync_2[k] != sync_d[k]) || (sync_2[k] == stable[k])) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == DB_MAX) begin
                    stable[k] <= sync_2[k];
                    db_cnt[k] <= '0;
                end else begin
                    db_cnt[k] <= db_cnt[k] + 1'b1;
                end
            end
        end
    end

    assign key_evt = stable_d & ~stable;

    logic up_evt;
    logic down_evt;
    logic slct_evt;
    logic pause_evt;

    assign up_evt    = key_evt[K_UP];
    assign down_evt  = key_evt[K_DOWN];
    assign slct_evt  = key_evt[K_SLCT];
    assign pause_evt = key_evt[K_PAUSE];

`ifndef PAUSE_EN
    logic unused_pause;
    assign unused_pause = pause_evt;
`endif

    // ---------------- sequencer ----------------
    state_t           state;
    state_t           state_nxt;
    logic [2:0]       cursor_nxt;
    logic [2:0]       sel_nxt;
    logic [SEC_W-1:0] sec_cnt;
    logic [SEC_W-1:0] sec_nxt;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state        <= S_MENU;
            cursor       <= '0;
            selected_lvl <= '0;
            sec_cnt      <= '0;
        end else begin
            state        <= state_nxt;
            cursor       <= cursor_nxt;
            selected_lvl <= sel_nxt;
            sec_cnt      <= sec_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cursor_nxt = cursor;
        sel_nxt    = selected_lvl;
        sec_nxt    = sec_cnt;
        case (state)
            S_MENU: begin
                if (slct_evt) begin
                    sel_nxt   = cursor;
                    state_nxt = S_LOAD;
                end else if (down_evt && !up_evt) begin
                    cursor_nxt = (cursor == LAST_LVL) ? 3'd0 : cursor + 3'd1;
                end else if (up_evt && !down_evt) begin
                    cursor_nxt = (cursor == 3'd0) ? LAST_LVL : cursor - 3'd1;
                end
            end
            S_LOAD: begin
                state_nxt = S_PLAY;
            end
            S_PLAY: begin
                if (player_dead) begin
                    state_nxt = S_LOSE;
                    sec_nxt   = '0;
                end else if (lvl_won) begin
                    state_nxt = S_WIN;
                    sec_nxt   = '0;
                end
`ifdef PAUSE_EN
                else if (pause_evt) begin
                    state_nxt = S_PAUSE;
                end
`endif
            end
            S_PAUSE: begin
`ifdef PAUSE_EN
                if (slct_evt) begin
                    state_nxt  = S_MENU;
                    cursor_nxt = selected_lvl;
                end else if (pause_evt) begin
                    state_nxt = S_PLAY;
                end
`else
                state_nxt = S_MENU;
`endif
            end
            S_WIN: begin
                if (slct_evt) begin
                    state_nxt  = S_MENU;
                    cursor_nxt = selected_lvl;
                end else if (oneSec) begin
                    if (sec_cnt == SEC_LAST) begin
                        // Last level won: back to the menu with the cursor on the first row.
                        if (selected_lvl < LAST_LVL) begin
                            sel_nxt   = selected_lvl + 3'd1;
                            state_nxt = S_LOAD;
                        end else begin
                            state_nxt  = S_MENU;
                            cursor_nxt = 3'd0;
                        end
                    end else begin
                        sec_nxt = sec_cnt + 1'b1;
                    end
                end
            end
            S_LOSE: begin
                if (slct_evt) begin
                    state_nxt  = S_MENU;
                    cursor_nxt = selected_lvl;
                end else if (oneSec) begin
                    if (sec_cnt == SEC_LAST) begin
                        state_nxt = S_LOAD;
                    end else begin
                        sec_nxt = sec_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = S_MENU;
            end
        endcase
    end

    assign menu_screen_on = (state == S_MENU);
    assign game_load      = (state == S_LOAD);
    assign game_run       = (state == S_PLAY);
    assign win_screen_on  = (state == S_WIN);
    assign lose_screen_on = (state == S_LOSE);
    assign state_dbg      = state;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed vector table, hand sequences for reset/pause, and random actions vs a screen-level model.
module tb_game_flow_ctrl;

    localparam int NL = 5;
    localparam int DB = 4;
    localparam int ES = 2;

    localparam int A_UP     = 0;
    localparam int A_DOWN   = 1;
    localparam int A_SLCT   = 2;
    localparam int A_WON    = 3;
    localparam int A_DEAD   = 4;
    localparam int A_BOTH   = 5;
    localparam int A_SEC    = 6;
    localparam int A_PAUSE  = 7;
    localparam int A_UPDN   = 8;
    localparam int A_BOUNCE = 9;

    localparam int M_MENU   = 0;
    localparam int M_PLAY   = 1;
    localparam int M_WIN    = 2;
    localparam int M_LOSE   = 3;
    localparam int M_PAUSED = 4;

    logic       clk = 1'b0;
    logic       resetN;
    logic       oneSec;
    logic       up_keyN;
    logic       down_keyN;
    logic       slct_keyN;
    logic       pause_keyN;
    logic       lvl_won;
    logic       player_dead;
    logic       menu_screen_on;
    logic       game_run;
    logic       game_load;
    logic       win_screen_on;
    logic       lose_screen_on;
    logic [2:0] cursor;
    logic [2:0] selected_lvl;
    logic [2:0] state_dbg;

    game_flow_ctrl #(
        .NUM_LEVELS     (NL),
        .DEBOUNCE_CYCLES(DB),
        .END_SCREEN_SECS(ES)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .oneSec        (oneSec),
        .up_keyN       (up_keyN),
        .down_keyN     (down_keyN),
        .slct_keyN     (slct_keyN),
        .pause_keyN    (pause_keyN),
        .lvl_won       (lvl_won),
        .player_dead   (player_dead),
        .menu_screen_on(menu_screen_on),
        .game_run      (game_run),
        .game_load     (game_load),
        .win_screen_on (win_screen_on),
        .lose_screen_on(lose_screen_on),
        .cursor        (cursor),
        .selected_lvl  (selected_lvl),
        .state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int load_seen = 0;

    always @(negedge clk) begin
        if (game_load === 1'b1) load_seen++;
    end

    typedef struct {
        int act;
        int cur;
        int sel;
        int mode;
        int loads;
    } vec_t;

    vec_t tbl[$];

    // screen-level reference model
    int m_mode;
    int m_cur;
    int m_sel;
    int m_secs;
    int m_loads;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic int flags_of(input int mode);
        case (mode)
            M_MENU:  return 8;
            M_PLAY:  return 4;
            M_WIN:   return 2;
            M_LOSE:  return 1;
            default: return 0;
        endcase
    endfunction

    task automatic chk_all(input string tag, input int cur, input int sel, input int mode, input int loads);
        int flags;
        flags = {28'd0, menu_screen_on, game_run, win_screen_on, lose_screen_on};
        chk({tag, " cursor"}, int'(cursor), cur);
        chk({tag, " selected_lvl"}, int'(selected_lvl), sel);
        chk({tag, " screen_flags"}, flags, flags_of(mode));
        chk({tag, " game_load_cycles"}, load_seen, loads);
    endtask

    task automatic add(input int a, input int c, input int s, input int m, input int l);
        vec_t v;
        v.act = a; v.cur = c; v.sel = s; v.mode = m; v.loads = l;
        tbl.push_back(v);
    endtask

    task automatic press(input logic [3:0] m);
        @(negedge clk);
        up_keyN    = ~m[0];
        down_keyN  = ~m[1];
        slct_keyN  = ~m[2];
        pause_keyN = ~m[3];
        repeat (12) @(negedge clk);
        up_keyN = 1'b1; down_keyN = 1'b1; slct_keyN = 1'b1; pause_keyN = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic pulse(input logic w, input logic d, input logic s);
        @(negedge clk);
        lvl_won = w; player_dead = d; oneSec = s;
        @(negedge clk);
        lvl_won = 1'b0; player_dead = 1'b0; oneSec = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic bounce();
        @(negedge clk);
        repeat (5) begin
            down_keyN = 1'b0;
            repeat (2) @(negedge clk);
            down_keyN = 1'b1;
            repeat (2) @(negedge clk);
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic do_act(input int a);
        load_seen = 0;
        case (a)
            A_UP:     press(4'b0001);
            A_DOWN:   press(4'b0010);
            A_SLCT:   press(4'b0100);
            A_PAUSE:  press(4'b1000);
            A_UPDN:   press(4'b0011);
            A_WON:    pulse(1'b1, 1'b0, 1'b0);
            A_DEAD:   pulse(1'b0, 1'b1, 1'b0);
            A_BOTH:   pulse(1'b1, 1'b1, 1'b0);
            A_SEC:    pulse(1'b0, 1'b0, 1'b1);
            A_BOUNCE: bounce();
            default:  ;
        endcase
    endtask

    task automatic m_apply(input int a);
        m_loads = 0;
        case (m_mode)
            M_MENU: begin
                if (a == A_SLCT) begin
                    m_sel = m_cur; m_mode = M_PLAY; m_loads = 1;
                end else if (a == A_DOWN) m_cur = (m_cur + 1) % NL;
                else if (a == A_UP) m_cur = (m_cur + NL - 1) % NL;
            end
            M_PLAY: begin
                if (a == A_DEAD || a == A_BOTH) begin
                    m_mode = M_LOSE; m_secs = 0;
                end else if (a == A_WON) begin
                    m_mode = M_WIN; m_secs = 0;
                end
`ifdef PAUSE_EN
                else if (a == A_PAUSE) m_mode = M_PAUSED;
`endif
            end
            M_PAUSED: begin
                if (a == A_SLCT) begin
                    m_mode = M_MENU; m_cur = m_sel;
                end else if (a == A_PAUSE) m_mode = M_PLAY;
            end
            default: begin
                if (a == A_SLCT) begin
                    m_mode = M_MENU; m_cur = m_sel;
                end else if (a == A_SEC) begin
                    m_secs++;
                    if (m_secs == ES) begin
                        if (m_mode == M_LOSE) begin
                            m_mode = M_PLAY; m_loads = 1;
                        end else if (m_sel < NL - 1) begin
                            m_sel++; m_mode = M_PLAY; m_loads = 1;
                        end else begin
                            m_mode = M_MENU; m_cur = 0;
                        end
                    end
                end
            end
        endcase
    endtask

    task automatic reset_edge();
        @(negedge clk);
        resetN = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        load_seen = 0;
    endtask

    initial begin
        resetN = 1'b0; oneSec = 1'b0; lvl_won = 1'b0; player_dead = 1'b0;
        up_keyN = 1'b1; down_keyN = 1'b1; slct_keyN = 1'b1; pause_keyN = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset game_load", int'(game_load), 0);
        resetN = 1'b1;
        load_seen = 0;
        @(negedge clk);
        chk_all("reset", 0, 0, M_MENU, 0);

        // directed vectors
        add(A_DOWN, 1, 0, M_MENU, 0);
        add(A_DOWN, 2, 0, M_MENU, 0);
        add(A_DOWN, 3, 0, M_MENU, 0);
        add(A_UP,   2, 0, M_MENU, 0);
        add(A_UP,   1, 0, M_MENU, 0);
        add(A_UP,   0, 0, M_MENU, 0);
        add(A_UP,   4, 0, M_MENU, 0);
        add(A_BOUNCE, 4, 0, M_MENU, 0);
        add(A_UPDN, 4, 0, M_MENU, 0);
        add(A_DOWN, 0, 0, M_MENU, 0);
        add(A_UP,   4, 0, M_MENU, 0);
        add(A_UP,   3, 0, M_MENU, 0);
        add(A_UP,   2, 0, M_MENU, 0);
        add(A_SLCT, 2, 2, M_PLAY, 1);
        add(A_BOTH, 2, 2, M_LOSE, 0);
        add(A_SEC,  2, 2, M_LOSE, 0);
        add(A_SEC,  2, 2, M_PLAY, 1);
        add(A_WON,  2, 2, M_WIN,  0);
        add(A_SEC,  2, 2, M_WIN,  0);
        add(A_SEC,  2, 3, M_PLAY, 1);
        add(A_DEAD, 2, 3, M_LOSE, 0);
        add(A_SEC,  2, 3, M_LOSE, 0);
        add(A_SEC,  2, 3, M_PLAY, 1);
        add(A_WON,  2, 3, M_WIN,  0);
        add(A_SEC,  2, 3, M_WIN,  0);
        add(A_SEC,  2, 4, M_PLAY, 1);
        add(A_WON,  2, 4, M_WIN,  0);
        add(A_SEC,  2, 4, M_WIN,  0);
        add(A_SEC,  0, 4, M_MENU, 0);
        add(A_DOWN, 1, 4, M_MENU, 0);
        add(A_SLCT, 1, 1, M_PLAY, 1);
        add(A_WON,  1, 1, M_WIN,  0);
        add(A_SEC,  1, 1, M_WIN,  0);
        add(A_SEC,  1, 2, M_PLAY, 1);
        add(A_DOWN, 1, 2, M_PLAY, 0);
        add(A_SLCT, 1, 2, M_PLAY, 0);
        add(A_WON,  1, 2, M_WIN,  0);
        add(A_SLCT, 2, 2, M_MENU, 0);
        add(A_WON,  2, 2, M_MENU, 0);
        add(A_DEAD, 2, 2, M_MENU, 0);
        add(A_SEC,  2, 2, M_MENU, 0);
        add(A_PAUSE, 2, 2, M_MENU, 0);
        add(A_SLCT, 2, 2, M_PLAY, 1);
        add(A_DEAD, 2, 2, M_LOSE, 0);
        add(A_SEC,  2, 2, M_LOSE, 0);
        add(A_SLCT, 2, 2, M_MENU, 0);
        add(A_SLCT, 2, 2, M_PLAY, 1);
        add(A_DEAD, 2, 2, M_LOSE, 0);
        add(A_SEC,  2, 2, M_LOSE, 0);
        add(A_SEC,  2, 2, M_PLAY, 1);

        foreach (tbl[i]) begin
            do_act(tbl[i].act);
            chk_all($sformatf("vec%0d", i), tbl[i].cur, tbl[i].sel, tbl[i].mode, tbl[i].loads);
        end

        // reset while the win screen is up
        do_act(A_WON);
        chk("pre-reset win", int'(win_screen_on), 1);
        reset_edge();
        chk_all("reset in win", 0, 0, M_MENU, 0);

        // random actions against the model
        m_mode = M_MENU; m_cur = 0; m_sel = 0; m_secs = 0; m_loads = 0;
        for (int n = 0; n < 80; n++) begin
            int a;
            a = $urandom_range(0, 8);
            do_act(a);
            m_apply(a);
            chk_all($sformatf("rnd%0d act%0d", n, a), m_cur, m_sel, m_mode, m_loads);
        end

        // pause handling and reset from deep inside a game
        reset_edge();
        do_act(A_DOWN);
        chk_all("p down", 1, 0, M_MENU, 0);
        do_act(A_SLCT);
        chk_all("p slct", 1, 1, M_PLAY, 1);
`ifdef PAUSE_EN
        do_act(A_PAUSE);
        chk_all("p pause", 1, 1, M_PAUSED, 0);
        do_act(A_WON);
        chk_all("p won ignored", 1, 1, M_PAUSED, 0);
        do_act(A_DEAD);
        chk_all("p dead ignored", 1, 1, M_PAUSED, 0);
        do_act(A_PAUSE);
        chk_all("p resume", 1, 1, M_PLAY, 0);
        do_act(A_PAUSE);
        chk_all("p pause2", 1, 1, M_PAUSED, 0);
        do_act(A_SLCT);
        chk_all("p slct menu", 1, 1, M_MENU, 0);
        do_act(A_SLCT);
        chk_all("p slct2", 1, 1, M_PLAY, 1);
        do_act(A_PAUSE);
        chk_all("p pause3", 1, 1, M_PAUSED, 0);
`else
        do_act(A_PAUSE);
        chk_all("p pause inert", 1, 1, M_PLAY, 0);
`endif
        reset_edge();
        chk_all("p reset", 0, 0, M_MENU, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
